// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit holding the architectural
// HI/LO registers.
//
// A mult/multu/div/divu request is accepted in IDLE when start is high. The
// operands and op are captured, a down-counter is loaded with the op's
// latency, and the unit sits in RUN until the counter reaches zero. HI/LO are
// written only on that final edge. mthi/mtlo write HI/LO directly in IDLE.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   start      in   request strobe from the E stage, sampled every edge
//   MDopE[2:0] in   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                   7 reserved (treated as none)
//   A[31:0]    in   rs operand (dividend / multiplicand / mthi-mtlo source)
//   B[31:0]    in   rt operand (divisor / multiplier)
//   HI[31:0]   out  architectural HI
//   LO[31:0]   out  architectural LO
//   busy       out  registered, high while a mult/div is in flight
//   stall_req  out  combinational: busy | (start & MDopE in 1..4)
//
// Handshake: there is no ready signal. A request is taken on any edge where
// start=1 and the unit is IDLE; while busy, requests are dropped and the
// hazard unit is expected to hold the pipeline using stall_req.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDopE,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        stall_req
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          busy_q, busy_d;

    logic is_md_op;
    logic accept;
    logic done;

    assign is_md_op = (MDopE >= OP_MULT) && (MDopE <= OP_DIVU);
    assign accept   = (state_q == IDLE) && start && is_md_op;
    // Counter holds the cycles left; the edge that takes it from 1 to 0
    // is the completion edge.
    assign done     = (state_q == RUN) && (cnt_q <= CW'(1));

    // Arithmetic on the captured operands.
    logic [63:0] prod_s, prod_u;
    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed division is done on magnitudes and the signs reapplied, which
    // gives truncation toward zero and a remainder carrying the dividend's
    // sign. 0x80000000 / -1 falls out as LO=0x80000000, HI=0 because the
    // negations wrap in 32 bits.
    logic        b_zero;
    logic [31:0] b_safe;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;

    assign b_zero = (b_q == 32'd0);
    assign b_safe = b_zero ? 32'd1 : b_q;  // keeps the divider free of X when B=0
    assign a_neg  = a_q[31];
    assign b_neg  = b_safe[31];
    assign a_mag  = a_neg ? (32'd0 - a_q) : a_q;
    assign b_mag  = b_neg ? (32'd0 - b_safe) : b_safe;
    assign q_mag  = a_mag / b_mag;
    assign r_mag  = a_mag % b_mag;
    assign quot_s = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem_s  = a_neg ? (32'd0 - r_mag) : r_mag;
    assign quot_u = a_q / b_safe;
    assign rem_u  = a_q % b_safe;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: FSM, counter and operand capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    a_d     = A;
                    b_d     = B;
                    op_d    = MDopE;
                    cnt_d   = (MDopE <= OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: HI/LO commits and busy.
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        busy_d = (state_d == RUN);
        if (state_q == IDLE && start) begin
            if (MDopE == OP_MTHI) begin
                hi_d = A;
            end else if (MDopE == OP_MTLO) begin
                lo_d = A;
            end
        end
        if (done) begin
            case (op_q)
                OP_MULT:  {hi_d, lo_d} = prod_s;
                OP_MULTU: {hi_d, lo_d} = prod_u;
                OP_DIV: begin
                    if (!b_zero) begin
                        hi_d = rem_s;
                        lo_d = quot_s;
                    end
                end
                OP_DIVU: begin
                    if (!b_zero) begin
                        hi_d = rem_u;
                        lo_d = quot_u;
                    end
                end
                default: ;
            endcase
        end
    end

    assign HI        = hi_q;
    assign LO        = lo_q;
    assign busy      = busy_q;
    assign stall_req = busy_q | (start & is_md_op);

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  MDopE;
    logic [31:0] A, B;
    logic [31:0] HI, LO;
    logic        busy, stall_req;

    int tests = 0;
    int fails = 0;

    // Architectural model of HI/LO.
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    always #5 clk = ~clk;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .MDopE(MDopE),
        .A(A), .B(B), .HI(HI), .LO(LO), .busy(busy), .stall_req(stall_req)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference semantics from the instruction definitions, using 64-bit
    // integer arithmetic.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin p = 64'(sa * sb); hi_m = p[63:32]; lo_m = p[31:0]; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
            3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
            3'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
            3'd5: hi_m = a;
            3'd6: lo_m = a;
            default: ;
        endcase
    endtask

    // Issue a mult/div, count busy cycles, optionally throw ignored requests
    // at the unit while it runs, then check the committed result.
    task automatic do_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n, input bit junk);
        int          cnt;
        logic [31:0] old_hi, old_lo;
        old_hi = hi_m;
        old_lo = lo_m;
        start = 1'b1; MDopE = op; A = a; B = b;
        #1;
        check({tag, "_stall_req"}, 32'(stall_req), 32'd1);
        step();
        model_op(op, a, b);
        cnt = 0;
        while (busy === 1'b1 && cnt < 60) begin
            check({tag, "_stall_run"}, 32'(stall_req), 32'd1);
            check({tag, "_hi_hold"}, HI, old_hi);
            check({tag, "_lo_hold"}, LO, old_lo);
            if (junk) begin
                start = 1'b1;
                A = $urandom;
                B = $urandom;
                if (cnt == 1)      MDopE = 3'd3;
                else if (cnt == 2) MDopE = 3'd5;
                else               MDopE = 3'($urandom_range(0, 7));
            end else begin
                start = 1'b0;
            end
            step();
            cnt++;
        end
        start = 1'b0; MDopE = 3'd0;
        check({tag, "_busy_cycles"}, 32'(cnt), 32'(n));
        check({tag, "_hi"}, HI, hi_m);
        check({tag, "_lo"}, LO, lo_m);
    endtask

    // mthi / mtlo / no-op requests: single edge, never busy.
    task automatic do_simple(input string tag, input logic [2:0] op, input logic [31:0] a);
        start = 1'b1; MDopE = op; A = a; B = $urandom;
        #1;
        check({tag, "_stall_req"}, 32'(stall_req), 32'd0);
        step();
        start = 1'b0; MDopE = 3'd0;
        model_op(op, a, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_hi"}, HI, hi_m);
        check({tag, "_lo"}, LO, lo_m);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; MDopE = 3'd0; A = 32'd0; B = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall_idle", 32'(stall_req), 32'd0);
        start = 1'b1; MDopE = 3'd1;
        #1;
        check("rst_stall_mult", 32'(stall_req), 32'd1);
        MDopE = 3'd7;
        #1;
        check("rst_stall_rsvd", 32'(stall_req), 32'd0);
        start = 1'b0; MDopE = 3'd0;
        step();

        // Directed cases.
        do_md("mult_neg", 3'd1, 32'hFFFFFFFE, 32'd3, MC, 1'b0);
        check("mult_neg_hi_const", HI, 32'hFFFFFFFF);
        check("mult_neg_lo_const", LO, 32'hFFFFFFFA);

        do_md("multu", 3'd2, 32'hFFFFFFFF, 32'd2, MC, 1'b0);
        check("multu_hi_const", HI, 32'h00000001);
        check("multu_lo_const", LO, 32'hFFFFFFFE);

        do_md("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, DC, 1'b0);
        check("div_neg_lo_const", LO, 32'hFFFFFFFD);
        check("div_neg_hi_const", HI, 32'hFFFFFFFF);

        do_md("divu_zero", 3'd4, 32'h12345678, 32'd0, DC, 1'b0);
        check("divu_zero_lo_const", LO, 32'hFFFFFFFD);
        check("divu_zero_hi_const", HI, 32'hFFFFFFFF);

        do_simple("mthi", 3'd5, 32'h12345678);
        do_simple("mtlo", 3'd6, 32'h9ABCDEF0);
        check("mthi_const", HI, 32'h12345678);
        check("mtlo_const", LO, 32'h9ABCDEF0);

        do_md("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, DC, 1'b0);
        check("div_ovf_lo_const", LO, 32'h80000000);
        check("div_ovf_hi_const", HI, 32'h00000000);

        do_md("mult_ignore", 3'd1, 32'h00012345, 32'hFFFF0003, MC, 1'b1);

        do_simple("op_none", 3'd0, 32'hDEADBEEF);
        do_simple("op_rsvd", 3'd7, 32'hCAFEF00D);

        // Reset in the middle of a divide aborts it.
        do_simple("pre_abort_mthi", 3'd5, 32'h5555AAAA);
        start = 1'b1; MDopE = 3'd3; A = 32'd100; B = 32'd7;
        step();
        start = 1'b0; MDopE = 3'd0;
        repeat (3) step();
        check("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (DC + 3) step();
        check("abort_hi_later", HI, 32'd0);
        check("abort_lo_later", LO, 32'd0);
        check("abort_busy_later", 32'(busy), 32'd0);

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            case (op)
                3'd1, 3'd2: do_md("rand_mult", op, ra, rb, MC, 1'b1);
                3'd3, 3'd4: do_md("rand_div", op, ra, rb, DC, 1'b1);
                default:    do_simple("rand_simple", op, ra);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
